// File: rtl/fmul_pipe.sv
// Purpose : parametrised IEEE-754-style multiplier (flush-to-zero, round-to-nearest-even).
// Latency : 3 cycles, one operation per cycle. S3 is the output register.
// Backpressure: a stage loads only when its downstream is empty or moving; in_ready is combinational from out_ready.
//
// Optional feature macro: FMUL_FLAGS_EN adds the flags port {invalid, overflow, underflow, inexact}.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake for x1, x2 (W = 1+EXP_W+MAN_W bits each)
//   out_valid/out_ready   result handshake for y (W bits)
//   flags                 exception flags, valid with out_valid (FMUL_FLAGS_EN only)

module fmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   x1,
    input  logic [EXP_W+MAN_W:0]   x2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   y
`ifdef FMUL_FLAGS_EN
    ,
    output logic [3:0]             flags
`endif
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * (MAN_W + 1);
    // Exponent arithmetic carries two extra bits: one for the sum of two
    // biased exponents, one for the sign after the bias is removed.
    localparam int XW = EXP_W + 2;

    localparam logic signed [XW-1:0] BIAS_X = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Stall chain
    // ------------------------------------------------------------------
    logic r1_vld, r2_vld, r3_vld;
    logic w_s1_en, w_s2_en, w_s3_en;

    assign w_s3_en  = !r3_vld || out_ready;
    assign w_s2_en  = !r2_vld || w_s3_en;
    assign w_s1_en  = !r1_vld || w_s2_en;
    assign in_ready = w_s1_en;

    // ------------------------------------------------------------------
    // S1: unpack, classify, exponent sum, significand product
    // ------------------------------------------------------------------
    logic               w_sa, w_sb, w_sign;
    logic [EXP_W-1:0]   w_ea, w_eb;
    logic [MAN_W-1:0]   w_fa, w_fb;
    logic               w_a_zero, w_b_zero, w_a_emax, w_b_emax;
    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic               w_spec;
    logic [W-1:0]       w_spec_val;
    logic [PW-1:0]      w_prod;
    logic signed [XW-1:0] w_exp_sum;

    assign w_sa = x1[W-1];
    assign w_sb = x2[W-1];
    assign w_ea = x1[W-2 -: EXP_W];
    assign w_eb = x2[W-2 -: EXP_W];
    assign w_fa = x1[MAN_W-1:0];
    assign w_fb = x2[MAN_W-1:0];

    // A zero exponent covers both true zeros and subnormals (flushed to zero).
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_emax = &w_ea;
    assign w_b_emax = &w_eb;
    assign w_a_nan  = w_a_emax && (|w_fa);
    assign w_b_nan  = w_b_emax && (|w_fb);
    assign w_a_inf  = w_a_emax && !(|w_fa);
    assign w_b_inf  = w_b_emax && !(|w_fb);
    assign w_sign   = w_sa ^ w_sb;

    assign w_prod    = PW'({1'b1, w_fa}) * PW'({1'b1, w_fb});
    assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS_X;

    // Special operands decide the result here; the arithmetic path is
    // still computed but ignored downstream when w_spec is set.
    always_comb begin
        w_spec     = 1'b1;
        w_spec_val = QNAN;
        if (w_a_nan || w_b_nan) begin
            w_spec_val = QNAN;
        end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
            w_spec_val = QNAN;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_val = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_a_zero || w_b_zero) begin
            w_spec_val = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

`ifdef FMUL_FLAGS_EN
    logic w_inv;
    // Signalling NaN: fraction nonzero with the quiet bit clear.
    assign w_inv = (w_a_nan && !w_fa[MAN_W-1]) || (w_b_nan && !w_fb[MAN_W-1]) ||
                   (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf);
`endif

    logic                 r1_sign, r1_spec;
    logic signed [XW-1:0] r1_exp;
    logic [PW-1:0]        r1_prod;
    logic [W-1:0]         r1_spec_val;
`ifdef FMUL_FLAGS_EN
    logic                 r1_inv;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_vld      <= 1'b0;
            r1_sign     <= 1'b0;
            r1_spec     <= 1'b0;
            r1_exp      <= '0;
            r1_prod     <= '0;
            r1_spec_val <= '0;
`ifdef FMUL_FLAGS_EN
            r1_inv      <= 1'b0;
`endif
        end else begin
            if (w_s1_en) begin
                r1_vld <= in_valid;
            end
            if (w_s1_en && in_valid) begin
                r1_sign     <= w_sign;
                r1_spec     <= w_spec;
                r1_exp      <= w_exp_sum;
                r1_prod     <= w_prod;
                r1_spec_val <= w_spec_val;
`ifdef FMUL_FLAGS_EN
                r1_inv      <= w_inv;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: normalise by at most one bit, form guard/round/sticky
    // ------------------------------------------------------------------
    // The product of two [1,2) significands lies in [1,4); the leading one
    // sits at PW-1 or PW-2. w_norm drops that leading one.
    logic [PW-2:0]        w_norm;
    logic signed [XW-1:0] w_exp_n;

    assign w_norm  = r1_prod[PW-1] ? r1_prod[PW-2:0] : {r1_prod[PW-3:0], 1'b0};
    assign w_exp_n = r1_exp + {{(XW-1){1'b0}}, r1_prod[PW-1]};

    logic                 r2_sign, r2_spec, r2_g, r2_r, r2_s;
    logic signed [XW-1:0] r2_exp;
    logic [MAN_W-1:0]     r2_frac;
    logic [W-1:0]         r2_spec_val;
`ifdef FMUL_FLAGS_EN
    logic                 r2_inv;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_vld      <= 1'b0;
            r2_sign     <= 1'b0;
            r2_spec     <= 1'b0;
            r2_g        <= 1'b0;
            r2_r        <= 1'b0;
            r2_s        <= 1'b0;
            r2_exp      <= '0;
            r2_frac     <= '0;
            r2_spec_val <= '0;
`ifdef FMUL_FLAGS_EN
            r2_inv      <= 1'b0;
`endif
        end else begin
            if (w_s2_en) begin
                r2_vld <= r1_vld;
            end
            if (w_s2_en && r1_vld) begin
                r2_sign     <= r1_sign;
                r2_spec     <= r1_spec;
                r2_exp      <= w_exp_n;
                r2_frac     <= w_norm[PW-2 -: MAN_W];
                r2_g        <= w_norm[MAN_W];
                r2_r        <= w_norm[MAN_W-1];
                r2_s        <= |w_norm[MAN_W-2:0];
                r2_spec_val <= r1_spec_val;
`ifdef FMUL_FLAGS_EN
                r2_inv      <= r1_inv;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: round to nearest even, range check, pack
    // ------------------------------------------------------------------
    logic                 w_rnd_up, w_ovf, w_unf;
    logic [MAN_W:0]       w_frac_r;
    logic signed [XW-1:0] w_exp_r;
    logic [W-1:0]         w_y3;

    assign w_rnd_up = r2_g && (r2_r || r2_s || r2_frac[0]);
    // The hidden bit is always one here, so a carry out of the fraction is
    // the same as a carry out of the full significand: the fraction wraps
    // to zero and the exponent steps up by one.
    assign w_frac_r = {1'b0, r2_frac} + {{MAN_W{1'b0}}, w_rnd_up};
    assign w_exp_r  = r2_exp + {{(XW-1){1'b0}}, w_frac_r[MAN_W]};
    assign w_ovf    = !w_exp_r[XW-1] && (w_exp_r >= EMAX_X);
    assign w_unf    = w_exp_r[XW-1] || (w_exp_r == '0);

`ifdef FMUL_FLAGS_EN
    logic       w_inexact;
    logic [3:0] w_f3;
    assign w_inexact = r2_g || r2_r || r2_s;
`endif

    always_comb begin
        w_y3 = {r2_sign, w_exp_r[EXP_W-1:0], w_frac_r[MAN_W-1:0]};
`ifdef FMUL_FLAGS_EN
        w_f3 = {3'b000, w_inexact};
`endif
        if (r2_spec) begin
            w_y3 = r2_spec_val;
`ifdef FMUL_FLAGS_EN
            w_f3 = {r2_inv, 3'b000};
`endif
        end else if (w_unf) begin
            w_y3 = {r2_sign, {(W-1){1'b0}}};
`ifdef FMUL_FLAGS_EN
            w_f3 = 4'b0011;
`endif
        end else if (w_ovf) begin
            w_y3 = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FMUL_FLAGS_EN
            w_f3 = 4'b0101;
`endif
        end
    end

    logic [W-1:0] r3_y;
`ifdef FMUL_FLAGS_EN
    logic [3:0]   r3_flags;
`endif

    // Loading only on a valid upstream keeps y frozen while stalled and
    // quiet when the pipe drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_vld   <= 1'b0;
            r3_y     <= '0;
`ifdef FMUL_FLAGS_EN
            r3_flags <= 4'b0000;
`endif
        end else begin
            if (w_s3_en) begin
                r3_vld <= r2_vld;
            end
            if (w_s3_en && r2_vld) begin
                r3_y     <= w_y3;
`ifdef FMUL_FLAGS_EN
                r3_flags <= w_f3;
`endif
            end
        end
    end

    assign out_valid = r3_vld;
    assign y         = r3_y;
`ifdef FMUL_FLAGS_EN
    assign flags     = r3_flags;
`endif

endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point multiplier.
- Successor to the single-precision `fmul` unit: configurable exponent and mantissa widths, a fixed 3-stage pipeline, and valid/ready handshaking with backpressure on both sides.
- Sits between the issue logic and the FPU writeback, and accepts one operation per cycle when not stalled.

Parameters:
- EXP_W, 8: exponent field width in bits; must be at least 3.
- MAN_W, 23: stored fraction width in bits, hidden bit excluded; must be at least 2.
- Total word width W = 1 + EXP_W + MAN_W, giving binary32 at the defaults.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair x1/x2 is valid this cycle.
- in_ready  out  1  block accepts an operand pair this cycle.
- x1  in  W  operand A: sign, exponent, fraction.
- x2  in  W  operand B.
- out_valid  out  1  result y is valid.
- out_ready  in  1  consumer accepts y this cycle.
- y  out  W  product.
- flags  out  4  {invalid, overflow, underflow, inexact}; present only with FMUL_FLAGS_EN.

Behaviour:
- Reset (async assert, sync release): all stage valid bits cleared; out_valid=0; y=0; flags=0. Reset mid-operation discards all in-flight operations, with no partial output.
- Transfers:
  - Input transfer happens when in_valid && in_ready.
  - Output transfer happens when out_valid && out_ready.
- Pipeline stages:
  - S1: unpack fields, classify operands, XOR the signs, add the exponents and subtract the bias, form the (MAN_W+1)x(MAN_W+1) significand product.
  - S2: normalise (1-bit shift), form guard/round/sticky bits.
  - S3: round-to-nearest-even, detect overflow/underflow, pack the result. S3 is the output register.
- Latency and throughput: exactly 3 cycles from input transfer to out_valid when unstalled; throughput 1 operation per cycle.
- Stall rule:
  - Each stage advances when its downstream stage is empty or is itself advancing.
  - in_ready = !S1.valid || S1 advancing, so in_ready is combinational from out_ready through the chain.
  - While out_valid && !out_ready, y and flags stay stable.
  - At most 3 operations are in flight. When all 3 are held, in_ready=0.
- Simultaneous input and output transfer in one cycle is legal and loses no data.
- Arithmetic rules:
  - Subnormal inputs are treated as signed zero (flush-to-zero).
  - A result whose biased exponent is ≤0 after rounding flushes to signed zero and sets underflow and inexact.
  - Biased exponent ≥ 2^EXP_W−1 after rounding gives signed infinity and sets overflow and inexact.
  - A mantissa carry-out from rounding increments the exponent and is re-checked for overflow.
  - inexact is set when any of guard/round/sticky is nonzero.
- Special values:
  - Any NaN operand → canonical qNaN (sign 0, exponent all ones, fraction MSB 1, other fraction bits 0).
  - inf×0 → canonical qNaN and sets invalid.
  - inf×finite-nonzero → signed inf, with no flags raised.
  - zero×finite → signed zero.
  - sNaN operand → sets invalid.

Optional Feature:
- Macro: FMUL_FLAGS_EN.
- Defined: the flags port exists. Flags are registered alongside y through every stage and are valid exactly when out_valid.
- Undefined: the flags port and all flag logic are absent. Datapath results are bit-identical to the defined case.

Test Plan:
- Default params, out_ready=1, back-to-back operations; each result appears 3 cycles after its input, in order:
  - 0x40400000×0x40400000 → 0x41100000, flags=0.
  - 0x437F0000×0xC37F0000 → 0xC77E0100.
  - 0x3F800000×0x3F8CCCCD → 0x3F8CCCCD.
  - 0x40200000×0x40000000 → 0x40A00000.
- Zero and sign: 0x00000000×0x80000000 → 0x80000000. Subnormal 0x00000001×0x3F800000 → 0x00000000, no flags.
- Specials:
  - 0x7F800000×0x00000000 → 0x7FC00000, invalid=1.
  - 0x7F7FFFFF×0x40000000 → 0x7F800000, overflow=1, inexact=1.
  - 0x00800000×0x3F000000 → 0x00000000, underflow=1, inexact=1.
- Backpressure: hold out_ready=0 while presenting 5 valid operations.
  - in_ready drops after 3 accepts.
  - y stays stable while stalled.
  - Releasing out_ready drains all 5 in order with no loss or duplication.
- Reset with 3 operations in flight: assert rst asynchronously between edges.
  - out_valid=0 and y=0 immediately.
  - After release, a new 3×3 operation yields 0x41100000 at 3-cycle latency.
- Parameter EXP_W=5, MAN_W=10 (half precision): 0x4200×0x4200 (3×3) → 0x4880; 0x7BFF×0x4000 → 0x7C00 with overflow.
